// File: rtl/mem_pkg.sv
// Shared constants and FSM encoding for the memory-stage controller.
package mem_pkg;

  localparam int unsigned CTRL_W      = 14;
  localparam int unsigned CTRL_MEM_RD = 3;
  localparam int unsigned CTRL_MEM_WR = 4;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned WAIT_CNT_W  = 8;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter: clears on issue, counts WAIT cycles, flags TIMEOUT-1.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = mem_pkg::TIMEOUT_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  import mem_pkg::*;

  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + WAIT_CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == WAIT_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: issues dmem req/ack accesses, stalls upstream while
// an access is outstanding, and strobes out_valid into the M/W latch.
module mem_stage_ctrl #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned TIMEOUT     = mem_pkg::TIMEOUT_DEF,
  parameter int unsigned CTRL_MEM_RD = mem_pkg::CTRL_MEM_RD,
  parameter int unsigned CTRL_MEM_WR = mem_pkg::CTRL_MEM_WR
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_ALU_result,
  input  logic [31:0]       in_data_write,
  input  logic [4:0]        in_rd,
  input  logic [13:0]       in_ctrl_signals,
  input  logic [31:0]       in_PC_next,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              dmem_req,
  output logic              dmem_wren,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              out_valid,
  output logic [31:0]       out_ALU_result,
  output logic [31:0]       out_data_read,
  output logic [4:0]        out_rd,
  output logic [13:0]       out_ctrl_signals,
  output logic [31:0]       out_PC_next,
  output logic              stall,
  output logic              mem_err,
  output logic [31:0]       mem_access_count
);
  import mem_pkg::*;

  state_e      state_q, state_d;
  logic        is_st, is_ld, is_mem;
  logic        tmr_clr, tmr_en, tmr_tc;
  logic        cnt_inc, err_set;
  logic        mem_err_q;
  logic [31:0] acc_cnt_q;

  assign is_st  = in_ctrl_signals[CTRL_MEM_WR];
  assign is_ld  = in_ctrl_signals[CTRL_MEM_RD] & ~is_st;
  assign is_mem = in_valid & (is_ld | is_st);

  assign out_ALU_result   = in_ALU_result;
  assign out_rd           = in_rd;
  assign out_ctrl_signals = in_ctrl_signals;
  assign out_PC_next      = in_PC_next;
  assign dmem_addr        = in_ALU_result[ADDR_W-1:0];
  assign dmem_wdata       = in_data_write;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // Next-state and handshake outputs; reset overrides everything last.
  always_comb begin
    state_d       = state_q;
    dmem_req      = 1'b0;
    dmem_wren     = 1'b0;
    stall         = 1'b0;
    out_valid     = 1'b0;
    out_data_read = '0;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    cnt_inc       = 1'b0;
    err_set       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (is_mem) begin
          dmem_req  = 1'b1;
          dmem_wren = is_st;
          stall     = 1'b1;
          tmr_clr   = 1'b1;
          state_d   = WAIT;
        end else if (in_valid) begin
          out_valid = 1'b1;
        end
      end
      WAIT: begin
        dmem_req  = 1'b1;
        dmem_wren = is_st;
        if (dmem_ack) begin
          out_valid     = 1'b1;
          out_data_read = is_ld ? dmem_rdata : 32'd0;
          cnt_inc       = 1'b1;
          state_d       = IDLE;
        end else if (tmr_tc) begin
          out_valid = 1'b1;
          err_set   = 1'b1;
          state_d   = IDLE;
        end else begin
          stall  = 1'b1;
          tmr_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      dmem_req  = 1'b0;
      dmem_wren = 1'b0;
      stall     = 1'b0;
      out_valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_err_q <= 1'b0;
      acc_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (err_set) mem_err_q <= 1'b1;
      if (cnt_inc) acc_cnt_q <= acc_cnt_q + 32'd1;
    end
  end

  assign mem_err          = mem_err_q;
  assign mem_access_count = acc_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed ops push expected results,
// a negedge monitor pops and compares on every out_valid strobe.
module tb_mem_stage_ctrl;

  localparam logic [13:0] C_ALU = 14'h0000;
  localparam logic [13:0] C_LD  = 14'h0008;
  localparam logic [13:0] C_ST  = 14'h0010;
  localparam logic [13:0] C_BTH = 14'h0018;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_ALU_result, in_data_write, in_PC_next, dmem_rdata;
  logic [4:0]  in_rd;
  logic [13:0] in_ctrl_signals;
  logic        dmem_ack;
  logic        dmem_req, dmem_wren, out_valid, stall, mem_err;
  logic [11:0] dmem_addr;
  logic [31:0] dmem_wdata, out_ALU_result, out_data_read, out_PC_next, mem_access_count;
  logic [4:0]  out_rd;
  logic [13:0] out_ctrl_signals;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [13:0] ctrl;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  mem_stage_ctrl dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_ALU_result(in_ALU_result), .in_data_write(in_data_write), .in_rd(in_rd),
    .in_ctrl_signals(in_ctrl_signals), .in_PC_next(in_PC_next),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .dmem_wren(dmem_wren), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .out_valid(out_valid), .out_ALU_result(out_ALU_result),
    .out_data_read(out_data_read), .out_rd(out_rd),
    .out_ctrl_signals(out_ctrl_signals), .out_PC_next(out_PC_next),
    .stall(stall), .mem_err(mem_err), .mem_access_count(mem_access_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: every out_valid strobe must match the oldest expectation.
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_ALU_result", out_ALU_result, e.alu);
        check("out_data_read", out_data_read, e.data);
        check("out_rd", 32'(out_rd), 32'(e.rd));
        check("out_ctrl_signals", 32'(out_ctrl_signals), 32'(e.ctrl));
        check("out_PC_next", out_PC_next, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    dmem_ack = 1'b0;
    repeat (n) step();
  endtask

  // One instruction from issue to completion; ack_at=0 means never ack.
  task automatic run_op(input string name, input logic [13:0] ctrl,
                        input logic [31:0] alu, input logic [31:0] wdata,
                        input logic [31:0] rdata, input logic [4:0] rd,
                        input int ack_at, input bit idle_ack, input int exp_stalls,
                        input logic [31:0] exp_data, output int done_cyc);
    int  k      = 0;
    int  stalls = 0;
    bit  mem    = (ctrl[3] | ctrl[4]);
    exp_t e;
    e.alu = alu; e.data = exp_data; e.rd = rd; e.ctrl = ctrl; e.pc = alu + 32'h100;
    q.push_back(e);
    done_cyc        = -1;
    in_valid        = 1'b1;
    in_ctrl_signals = ctrl;
    in_ALU_result   = alu;
    in_data_write   = wdata;
    in_rd           = rd;
    in_PC_next      = alu + 32'h100;
    dmem_rdata      = rdata;
    forever begin
      dmem_ack = (k == 0) ? idle_ack : (ack_at != 0 && k == ack_at);
      @(negedge clock);
      if (k == 0) begin
        check({name, "_req"}, 32'(dmem_req), 32'(mem));
        if (mem) begin
          check({name, "_wren"}, 32'(dmem_wren), 32'(ctrl[4]));
          check({name, "_addr"}, 32'(dmem_addr), 32'(alu[11:0]));
          check({name, "_wdata"}, dmem_wdata, wdata);
        end
      end
      if (stall) stalls++;
      if (out_valid) begin
        done_cyc = cyc;
        break;
      end
      if (k >= 300) begin
        check({name, "_completion_timeout"}, 32'd0, 32'd1);
        break;
      end
      step();
      k++;
    end
    check({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stalls));
    step();
    dmem_ack = 1'b0;
  endtask

  initial begin
    int c0, c1, c2;
    reset = 1'b1; in_valid = 1'b1; in_ctrl_signals = C_LD; in_ALU_result = 32'h10;
    in_data_write = '0; in_rd = '0; in_PC_next = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    step();
    @(negedge clock);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0;
    idle(1);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    check("rst_count", mem_access_count, 32'd0);

    run_op("alu", C_ALU, 32'h1234, 32'h0, 32'h0, 5'd3, 0, 1'b0, 0, 32'h0, c0);
    idle(1);
    run_op("load", C_LD, 32'h010, 32'h0, 32'hDEADBEEF, 5'd7, 3, 1'b0, 3, 32'hDEADBEEF, c0);
    check("load_count", mem_access_count, 32'd1);
    // ack held during the issue cycle must be ignored
    run_op("store", C_ST, 32'h020, 32'hA5A5A5A5, 32'h12345678, 5'd9, 2, 1'b1, 2, 32'h0, c0);
    check("store_count", mem_access_count, 32'd2);
    run_op("both_bits", C_BTH, 32'h5021, 32'h0BADF00D, 32'h77777777, 5'd1, 1, 1'b0, 1, 32'h0, c0);
    check("both_count", mem_access_count, 32'd3);
    check("pre_timeout_err", 32'(mem_err), 32'd0);
    run_op("timeout", C_LD, 32'h030, 32'h0, 32'h55555555, 5'd4, 0, 1'b0, 16, 32'h0, c0);
    check("timeout_err", 32'(mem_err), 32'd1);
    check("timeout_count", mem_access_count, 32'd3);
    idle(2);
    check("err_sticky", 32'(mem_err), 32'd1);

    // Reset on the second WAIT cycle of a load abandons the access.
    in_valid = 1'b1; in_ctrl_signals = C_LD; in_ALU_result = 32'h040; dmem_ack = 1'b0;
    step(); step();
    reset = 1'b1;
    @(negedge clock);
    check("rstwait_req", 32'(dmem_req), 32'd0);
    check("rstwait_stall", 32'(stall), 32'd0);
    check("rstwait_out_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    check("rstwait_mem_err", 32'(mem_err), 32'd0);
    check("rstwait_count", mem_access_count, 32'd0);
    check("rstwait_idle_stall", 32'(stall), 32'd0);
    step();
    run_op("alu_after_rst", C_ALU, 32'hCAFE0001, 32'h0, 32'h0, 5'd2, 0, 1'b0, 0, 32'h0, c0);

    run_op("b2b0", C_LD, 32'h100, 32'h0, 32'h11111111, 5'd10, 1, 1'b0, 1, 32'h11111111, c0);
    run_op("b2b1", C_LD, 32'h101, 32'h0, 32'h22222222, 5'd11, 1, 1'b0, 1, 32'h22222222, c1);
    run_op("b2b2", C_LD, 32'h102, 32'h0, 32'h33333333, 5'd12, 1, 1'b0, 1, 32'h33333333, c2);
    check("b2b_gap01", 32'(c1 - c0), 32'd2);
    check("b2b_gap12", 32'(c2 - c1), 32'd2);
    check("b2b_count", mem_access_count, 32'd3);
    idle(3);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
